// File: rtl/eth_cmd_pkg.sv
// Shared types and register map for the multi-channel Ethernet command register file.
package eth_cmd_pkg;

  typedef enum logic [1:0] {
    TX_NONE    = 2'd0,
    TX_UDP     = 2'd1,
    TX_ARP_REQ = 2'd2,
    TX_ARP_REP = 2'd3
  } tx_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } tx_state_e;

  // Word offsets (addr[4:2]) inside the global page
  localparam logic [2:0] G_CTRL        = 3'd0;
  localparam logic [2:0] G_STATUS      = 3'd1;
  localparam logic [2:0] G_SMAC_HI     = 3'd2;
  localparam logic [2:0] G_SMAC_LO     = 3'd3;
  localparam logic [2:0] G_SIP         = 3'd4;
  localparam logic [2:0] G_COMMIT_GLOB = 3'd6;

  // Word offsets inside a channel page
  localparam logic [2:0] C_DMAC_HI = 3'd0;
  localparam logic [2:0] C_DMAC_LO = 3'd1;
  localparam logic [2:0] C_DIP     = 3'd2;
  localparam logic [2:0] C_SPORT   = 3'd3;
  localparam logic [2:0] C_DPORT   = 3'd4;
  localparam logic [2:0] C_ULEN    = 3'd5;
  localparam logic [2:0] C_COMMIT  = 3'd6;

  typedef struct packed {
    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
  } ch_cfg_t;

  typedef struct packed {
    logic [2:0] ch;
    tx_type_e   typ;
  } tx_req_t;

endpackage

// File: rtl/cmd_req_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a pop frees a slot for a same-cycle push.
module cmd_req_fifo #(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];
  assign level_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/eth_cmd_regs_mc.sv
// Multi-channel UDP/ARP command register file: shadow/active header fields with atomic
// commit, send-request queue and a valid/ready/done handshake toward the frame generator.
module eth_cmd_regs_mc
  import eth_cmd_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int Q_DEPTH = 4,
  parameter  int ADDR_W  = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [31:0]       i_cmd_data,
  input  logic              i_cmd_wr,
  input  logic              i_cmd_rd,
  output logic [31:0]       o_rd_data,
  output logic              o_rd_valid,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  input  logic              i_tx_done,
  output logic [1:0]        o_tx_type,
  output logic [CH_W-1:0]   o_tx_ch,
  output logic [47:0]       o_src_mac,
  output logic [47:0]       o_dst_mac,
  output logic [31:0]       o_src_ip,
  output logic [31:0]       o_dst_ip,
  output logic [15:0]       o_src_port,
  output logic [15:0]       o_dst_port,
  output logic [15:0]       o_udp_data_len
);

  localparam int PG_W  = ADDR_W - 5;
  localparam int LVL_W = $clog2(Q_DEPTH) + 1;

  tx_state_e       state_q;
  logic            tx_valid_q;
  logic [CH_W-1:0] tx_ch_q;
  tx_type_e        tx_type_q;
  logic            ovf_q, bad_ch_q, pend_glob_q;
  logic [47:0]     smac_sh_q, smac_act_q;
  logic [31:0]     sip_sh_q, sip_act_q;
  logic            rd_valid_q;
  logic [31:0]     rd_data_q, rd_d;

  ch_cfg_t         ch_sh  [N_CH];
  ch_cfg_t         ch_act [N_CH];
  logic [N_CH-1:0] pend_ch;

  // Address decode
  logic [PG_W-1:0] page;
  logic [2:0]      woff;
  logic [CH_W-1:0] pch;
  logic            is_glob, is_ch, wr_glob, wr_ch;
  logic            unused_addr;

  assign page        = i_cmd_addr[ADDR_W-1:5];
  assign woff        = i_cmd_addr[4:2];
  assign unused_addr = ^i_cmd_addr[1:0];
  assign is_glob     = (page == '0);
  assign is_ch       = !is_glob && (int'(page) <= N_CH);
  assign pch         = CH_W'(page - 1'b1);
  assign wr_glob     = i_cmd_wr && is_glob;
  assign wr_ch       = i_cmd_wr && is_ch;

  // CTRL decode and request queue
  logic             ctrl_wr, ctrl_bad, push_req, pop, in_flight;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  tx_req_t          push_data, head;

  assign ctrl_wr        = wr_glob && (woff == G_CTRL);
  assign push_data.ch   = i_cmd_data[10:8];
  assign push_data.typ  = tx_type_e'(i_cmd_data[1:0]);
  assign ctrl_bad       = ctrl_wr && (push_data.typ != TX_NONE) && (int'(push_data.ch) >= N_CH);
  assign push_req       = ctrl_wr && (push_data.typ != TX_NONE) && !ctrl_bad;
  assign pop            = tx_valid_q && i_tx_ready;
  assign in_flight      = (state_q == ST_BUSY);

  cmd_req_fifo #(
    .WIDTH ($bits(tx_req_t)),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // TX handshake FSM; ch/type stay latched from the offer until the next offer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_ch_q    <= '0;
      tx_type_q  <= TX_NONE;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) begin
          state_q    <= ST_OFFER;
          tx_valid_q <= 1'b1;
          tx_ch_q    <= CH_W'(head.ch);
          tx_type_q  <= head.typ;
        end
        ST_OFFER: if (i_tx_ready) begin
          state_q    <= ST_BUSY;
          tx_valid_q <= 1'b0;
        end
        ST_BUSY: if (i_tx_done) begin
          if (!fifo_empty) begin
            state_q    <= ST_OFFER;
            tx_valid_q <= 1'b1;
            tx_ch_q    <= CH_W'(head.ch);
            tx_type_q  <= head.typ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Global fields, sticky flags and global commit. A done pulse releases the
  // busy condition on the same edge, so pending commits land before the next offer.
  logic commit_glob, glob_req, glob_busy;

  assign commit_glob = wr_glob && (woff == G_COMMIT_GLOB);
  assign glob_req    = commit_glob || pend_glob_q;
  assign glob_busy   = in_flight && !i_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smac_sh_q   <= '0;
      smac_act_q  <= '0;
      sip_sh_q    <= '0;
      sip_act_q   <= '0;
      pend_glob_q <= 1'b0;
      ovf_q       <= 1'b0;
      bad_ch_q    <= 1'b0;
    end else begin
      if (wr_glob) begin
        case (woff)
          G_SMAC_HI: smac_sh_q[47:16] <= i_cmd_data;
          G_SMAC_LO: smac_sh_q[15:0]  <= i_cmd_data[15:0];
          G_SIP:     sip_sh_q         <= i_cmd_data;
          default: ;
        endcase
      end
      if (glob_req && !glob_busy) begin
        smac_act_q <= smac_sh_q;
        sip_act_q  <= sip_sh_q;
      end
      pend_glob_q <= glob_req && glob_busy;

      if (wr_glob && (woff == G_STATUS) && i_cmd_data[0]) ovf_q <= 1'b0;
      else if (push_req && fifo_full && !pop)             ovf_q <= 1'b1;
      if (wr_glob && (woff == G_STATUS) && i_cmd_data[1]) bad_ch_q <= 1'b0;
      else if (ctrl_bad)                                  bad_ch_q <= 1'b1;
    end
  end

  // Per-channel shadow/active registers with their own commit/pending
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ch_cfg_t sh_q, act_q;
    logic    pend_q, sel, req, busy;

    assign sel  = wr_ch && (pch == CH_W'(c));
    assign req  = (sel && (woff == C_COMMIT)) || pend_q;
    assign busy = in_flight && !i_tx_done && (tx_ch_q == CH_W'(c));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sh_q   <= '0;
        act_q  <= '0;
        pend_q <= 1'b0;
      end else begin
        if (sel) begin
          case (woff)
            C_DMAC_HI: sh_q.dst_mac[47:16] <= i_cmd_data;
            C_DMAC_LO: sh_q.dst_mac[15:0]  <= i_cmd_data[15:0];
            C_DIP:     sh_q.dst_ip         <= i_cmd_data;
            C_SPORT:   sh_q.src_port       <= i_cmd_data[15:0];
            C_DPORT:   sh_q.dst_port       <= i_cmd_data[15:0];
            C_ULEN:    sh_q.udp_len        <= i_cmd_data[15:0];
            default: ;
          endcase
        end
        if (req && !busy) act_q <= sh_q;
        pend_q <= req && busy;
      end
    end

    assign ch_sh[c]   = sh_q;
    assign ch_act[c]  = act_q;
    assign pend_ch[c] = pend_q;
  end

  // Read-back returns shadow copies; STATUS is sampled in the strobe cycle
  ch_cfg_t rd_cfg;
  assign rd_cfg = ch_sh[pch];

  always_comb begin
    rd_d = '0;
    if (is_glob) begin
      case (woff)
        G_STATUS:  rd_d = {7'd0, pend_glob_q, 8'(pend_ch), 8'(fifo_level),
                           5'd0, in_flight, bad_ch_q, ovf_q};
        G_SMAC_HI: rd_d = smac_sh_q[47:16];
        G_SMAC_LO: rd_d = {16'd0, smac_sh_q[15:0]};
        G_SIP:     rd_d = sip_sh_q;
        default:   rd_d = '0;
      endcase
    end else if (is_ch) begin
      case (woff)
        C_DMAC_HI: rd_d = rd_cfg.dst_mac[47:16];
        C_DMAC_LO: rd_d = {16'd0, rd_cfg.dst_mac[15:0]};
        C_DIP:     rd_d = rd_cfg.dst_ip;
        C_SPORT:   rd_d = {16'd0, rd_cfg.src_port};
        C_DPORT:   rd_d = {16'd0, rd_cfg.dst_port};
        C_ULEN:    rd_d = {16'd0, rd_cfg.udp_len};
        default:   rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= i_cmd_rd;
      if (i_cmd_rd) rd_data_q <= rd_d;
    end
  end

  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_tx_valid     = tx_valid_q;
  assign o_tx_ch        = tx_ch_q;
  assign o_tx_type      = tx_type_q;
  assign o_src_mac      = smac_act_q;
  assign o_src_ip       = sip_act_q;
  assign o_dst_mac      = ch_act[tx_ch_q].dst_mac;
  assign o_dst_ip       = ch_act[tx_ch_q].dst_ip;
  assign o_src_port     = ch_act[tx_ch_q].src_port;
  assign o_dst_port     = ch_act[tx_ch_q].dst_port;
  assign o_udp_data_len = ch_act[tx_ch_q].udp_len;

endmodule
